// File: rtl/cpu_sequencer_pkg.sv
// Shared definitions for the classy-core sequencer: opcodes, FSM states and defaults.
// Imported by the sequencer, its interface, and datapath decode.
package cpu_sequencer_pkg;

    localparam int INSTR_W             = 16;
    localparam int DEFAULT_PC_WIDTH    = 8;
    localparam int DEFAULT_STACK_DEPTH = 4;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ALU  = 4'h1,
        OP_JMP  = 4'h2,
        OP_JZ   = 4'h3,
        OP_JNZ  = 4'h4,
        OP_CALL = 4'h5,
        OP_RET  = 4'h6,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_e;

    function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] ir);
        return ir[INSTR_W-1:INSTR_W-4];
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Bundle between the sequencer and program memory / datapath.
// master = sequencer side, slave = memory/datapath side.
interface cpu_sequencer_if
    import cpu_sequencer_pkg::*;
#(
    parameter int PC_WIDTH = DEFAULT_PC_WIDTH
) ();

    logic [INSTR_W-1:0]  i_PMDATA;
    logic                i_ALU_Z;
    logic                i_stall;
    logic [PC_WIDTH-1:0] o_pm_addr;
    logic [INSTR_W-1:0]  o_ir;
    logic                o_alu_en;
    logic                o_reg_we;
    logic                o_halted;
    logic                o_fault;
    logic                o_illegal;

    modport master (
        input  i_PMDATA, i_ALU_Z, i_stall,
        output o_pm_addr, o_ir, o_alu_en, o_reg_we, o_halted, o_fault, o_illegal
    );

    modport slave (
        output i_PMDATA, i_ALU_Z, i_stall,
        input  o_pm_addr, o_ir, o_alu_en, o_reg_we, o_halted, o_fault, o_illegal
    );

endinterface

// File: rtl/cpu_sequencer_return_stack.sv
// Hardware return-address LIFO for CALL/RET. Push is ignored when full and pop
// when empty; the sequencer checks full/empty before issuing either.
module cpu_sequencer_return_stack #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_idx, rd_idx;

    assign full     = (cnt_q == DEPTH_CNT);
    assign empty    = (cnt_q == '0);
    assign wr_idx   = cnt_q[PTR_W-1:0];
    assign rd_idx   = wr_idx - PTR_W'(1);
    assign top_data = mem_q[rd_idx];

    always_comb begin
        cnt_d = cnt_q;
        mem_d = mem_q;
        if (push && !full) begin
            mem_d[wr_idx] = push_data;
            cnt_d         = cnt_q + 1'b1;
        end else if (pop && !empty) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Only the occupancy count is reset; stale entries are unreachable once cnt is 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: owns PC and IR, decodes opcodes into ALU/regfile
// strobes, resolves branches on the ALU zero flag and drives a CALL/RET stack.
module cpu_sequencer
    import cpu_sequencer_pkg::*;
#(
    parameter int PC_WIDTH    = DEFAULT_PC_WIDTH,
    parameter int STACK_DEPTH = DEFAULT_STACK_DEPTH
) (
    input logic             i_clk,
    input logic             i_reset,
    cpu_sequencer_if.master bus
);

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [INSTR_W-1:0]  ir_q, ir_d;
    logic                fault_q, fault_d;

    logic                alu_en, reg_we, illegal;
    logic                push, pop;
    logic                stk_full, stk_empty;
    logic [PC_WIDTH-1:0] stk_top;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] target;

    assign pc_inc = pc_q + 1'b1;
    assign target = ir_q[PC_WIDTH-1:0];

    cpu_sequencer_return_stack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (PC_WIDTH)
    ) u_stack (
        .clk       (i_clk),
        .rst       (i_reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

    // A stall freezes everything by leaving every *_d at its *_q and every strobe low.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        fault_d = fault_q;
        alu_en  = 1'b0;
        reg_we  = 1'b0;
        illegal = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;

        if (!bus.i_stall) begin
            case (state_q)
                S_FETCH: state_d = S_DECODE;
                S_DECODE: begin
                    ir_d    = bus.i_PMDATA;
                    state_d = S_EXEC;
                end
                S_EXEC: begin
                    state_d = S_FETCH;
                    case (opcode_of(ir_q))
                        OP_NOP: pc_d = pc_inc;
                        OP_ALU: begin
                            alu_en  = 1'b1;
                            pc_d    = pc_inc;
                            state_d = S_WB;
                        end
                        OP_JMP: pc_d = target;
                        OP_JZ:  pc_d = bus.i_ALU_Z ? target : pc_inc;
                        OP_JNZ: pc_d = bus.i_ALU_Z ? pc_inc : target;
                        OP_CALL: begin
                            if (stk_full) begin
                                fault_d = 1'b1;
                                state_d = S_HALT;
                            end else begin
                                push = 1'b1;
                                pc_d = target;
                            end
                        end
                        OP_RET: begin
                            if (stk_empty) begin
                                fault_d = 1'b1;
                                state_d = S_HALT;
                            end else begin
                                pop  = 1'b1;
                                pc_d = stk_top;
                            end
                        end
                        OP_HALT: state_d = S_HALT;
                        default: begin
                            illegal = 1'b1;
                            pc_d    = pc_inc;
                        end
                    endcase
                end
                S_WB: begin
                    reg_we  = 1'b1;
                    state_d = S_FETCH;
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            ir_q    <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            fault_q <= fault_d;
        end
    end

    // Strobes are suppressed while reset is held so an abandoned op never fires.
    assign bus.o_pm_addr = pc_q;
    assign bus.o_ir      = ir_q;
    assign bus.o_alu_en  = alu_en  & ~i_reset;
    assign bus.o_reg_we  = reg_we  & ~i_reset;
    assign bus.o_illegal = illegal & ~i_reset;
    assign bus.o_halted  = (state_q == S_HALT);
    assign bus.o_fault   = fault_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them against the bus.
module tb_cpu_sequencer;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] ir;
        logic        alu;
        logic        we;
        logic        ill;
        logic        halt;
        logic        flt;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pm [256];
    obs_t        expq[$];
    string       nameq[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc_no = 0;
    logic        exp_flt = 1'b0;

    cpu_sequencer_if #(.PC_WIDTH(8)) bus ();

    cpu_sequencer #(
        .PC_WIDTH    (8),
        .STACK_DEPTH (4)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Registered-read program memory
    always @(posedge clk) bus.i_PMDATA <= pm[bus.o_pm_addr];

    obs_t  mon_exp;
    obs_t  mon_act;
    string mon_name;

    always @(negedge clk) begin
        cyc_no++;
        if (expq.size() != 0) begin
            mon_exp  = expq.pop_front();
            mon_name = nameq.pop_front();
            mon_act  = {bus.o_pm_addr, bus.o_ir, bus.o_alu_en, bus.o_reg_we,
                        bus.o_illegal, bus.o_halted, bus.o_fault};
            n_cmp++;
            if (mon_act !== mon_exp) begin
                n_fail++;
                $display("FAIL %s @cycle %0d: got addr=%02h ir=%04h alu=%b we=%b ill=%b halt=%b flt=%b, expected addr=%02h ir=%04h alu=%b we=%b ill=%b halt=%b flt=%b",
                         mon_name, cyc_no, mon_act.addr, mon_act.ir, mon_act.alu, mon_act.we,
                         mon_act.ill, mon_act.halt, mon_act.flt, mon_exp.addr, mon_exp.ir,
                         mon_exp.alu, mon_exp.we, mon_exp.ill, mon_exp.halt, mon_exp.flt);
            end
        end
    end

    task automatic cyc(input logic st, input logic rs, input bit chk, input string nm,
                       input logic [7:0] a, input logic [15:0] ir,
                       input logic alu, input logic we, input logic ill, input logic halt);
        @(posedge clk);
        #1;
        bus.i_stall = st;
        rst         = rs;
        if (chk) begin
            expq.push_back({a, ir, alu, we, ill, halt, exp_flt});
            nameq.push_back(nm);
        end
    endtask

    task automatic do_reset(input string nm);
        cyc(1'b0, 1'b1, 1'b0, nm, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_flt = 1'b0;
        cyc(1'b0, 1'b1, 1'b1, nm, 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // FETCH, DECODE, EXEC of a three-cycle instruction at address a
    task automatic seq3(input string nm, input logic [7:0] a, input logic [15:0] ir_old,
                        input logic [15:0] ir_new, input logic ill);
        cyc(1'b0, 1'b0, 1'b1, {nm, "_F"}, a, ir_old, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, {nm, "_D"}, a, ir_old, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, {nm, "_E"}, a, ir_new, 1'b0, 1'b0, ill, 1'b0);
    endtask

    task automatic seq_alu(input string nm, input logic [7:0] a, input logic [15:0] ir_old,
                           input logic [15:0] ir_new);
        cyc(1'b0, 1'b0, 1'b1, {nm, "_F"}, a, ir_old, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, {nm, "_D"}, a, ir_old, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, {nm, "_E"}, a, ir_new, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, {nm, "_W"}, a + 8'd1, ir_new, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic clear_pm();
        for (int i = 0; i < 256; i++) pm[i] = 16'h0000;
    endtask

    initial begin
        bus.i_stall = 1'b0;
        bus.i_ALU_Z = 1'b0;
        clear_pm();

        // NOP stream
        do_reset("reset");
        seq3("nop0", 8'h00, 16'h0000, 16'h0000, 1'b0);
        seq3("nop1", 8'h01, 16'h0000, 16'h0000, 1'b0);
        seq3("nop2", 8'h02, 16'h0000, 16'h0000, 1'b0);

        // ALU op at 0: alu_en cycle 3, reg_we cycle 4, fetch 1 on cycle 5
        clear_pm();
        pm[0] = 16'h1000;
        do_reset("rst_alu");
        seq_alu("alu", 8'h00, 16'h0000, 16'h1000);
        seq3("alu_next", 8'h01, 16'h1000, 16'h0000, 1'b0);

        // JZ taken / not taken, JNZ taken
        clear_pm();
        pm[2] = 16'h3005;
        bus.i_ALU_Z = 1'b1;
        do_reset("rst_jz1");
        seq3("jz1_n0", 8'h00, 16'h0000, 16'h0000, 1'b0);
        seq3("jz1_n1", 8'h01, 16'h0000, 16'h0000, 1'b0);
        seq3("jz1", 8'h02, 16'h0000, 16'h3005, 1'b0);
        seq3("jz1_tgt", 8'h05, 16'h3005, 16'h0000, 1'b0);
        bus.i_ALU_Z = 1'b0;
        do_reset("rst_jz0");
        seq3("jz0_n0", 8'h00, 16'h0000, 16'h0000, 1'b0);
        seq3("jz0_n1", 8'h01, 16'h0000, 16'h0000, 1'b0);
        seq3("jz0", 8'h02, 16'h0000, 16'h3005, 1'b0);
        seq3("jz0_fall", 8'h03, 16'h3005, 16'h0000, 1'b0);
        clear_pm();
        pm[0] = 16'h4007;
        do_reset("rst_jnz");
        seq3("jnz", 8'h00, 16'h0000, 16'h4007, 1'b0);
        seq3("jnz_tgt", 8'h07, 16'h4007, 16'h0000, 1'b0);

        // CALL 0x10 from 0x20, RET back to 0x21
        clear_pm();
        pm[8'h00] = 16'h2020;
        pm[8'h20] = 16'h5010;
        pm[8'h10] = 16'h6000;
        do_reset("rst_call");
        seq3("jmp20", 8'h00, 16'h0000, 16'h2020, 1'b0);
        seq3("call", 8'h20, 16'h2020, 16'h5010, 1'b0);
        seq3("ret", 8'h10, 16'h5010, 16'h6000, 1'b0);
        seq3("ret_dst", 8'h21, 16'h6000, 16'h0000, 1'b0);

        // Five nested CALLs overflow a 4-deep stack
        clear_pm();
        pm[8'h00] = 16'h5030;
        pm[8'h30] = 16'h5040;
        pm[8'h40] = 16'h5050;
        pm[8'h50] = 16'h5060;
        pm[8'h60] = 16'h5070;
        do_reset("rst_ovf");
        seq3("call1", 8'h00, 16'h0000, 16'h5030, 1'b0);
        seq3("call2", 8'h30, 16'h5030, 16'h5040, 1'b0);
        seq3("call3", 8'h40, 16'h5040, 16'h5050, 1'b0);
        seq3("call4", 8'h50, 16'h5050, 16'h5060, 1'b0);
        seq3("call5", 8'h60, 16'h5060, 16'h5070, 1'b0);
        exp_flt = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, "ovf_halt0", 8'h60, 16'h5070, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, "ovf_halt1", 8'h60, 16'h5070, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, "ovf_halt2", 8'h60, 16'h5070, 1'b0, 1'b0, 1'b0, 1'b1);

        // RET on empty stack
        clear_pm();
        pm[0] = 16'h6000;
        do_reset("rst_unf");
        seq3("ret_empty", 8'h00, 16'h0000, 16'h6000, 1'b0);
        exp_flt = 1'b1;
        cyc(1'b0, 1'b0, 1'b1, "unf_halt", 8'h00, 16'h6000, 1'b0, 1'b0, 1'b0, 1'b1);

        // JMP to 0xFF, NOP there wraps PC to 0
        clear_pm();
        pm[8'h00] = 16'h20FF;
        do_reset("rst_wrap");
        seq3("jmpff", 8'h00, 16'h0000, 16'h20FF, 1'b0);
        seq3("nop_ff", 8'hFF, 16'h20FF, 16'h0000, 1'b0);
        seq3("wrap0", 8'h00, 16'h0000, 16'h20FF, 1'b0);

        // Illegal opcode pulse, then HALT (fault stays clear)
        clear_pm();
        pm[0] = 16'h9000;
        pm[1] = 16'hF000;
        do_reset("rst_ill");
        seq3("ill", 8'h00, 16'h0000, 16'h9000, 1'b1);
        seq3("halt_op", 8'h01, 16'h9000, 16'hF000, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, "halt0", 8'h01, 16'hF000, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, "halt1", 8'h01, 16'hF000, 1'b0, 1'b0, 1'b0, 1'b1);

        // Stall held 3 cycles in EXEC of an ALU op
        clear_pm();
        pm[0] = 16'h1000;
        do_reset("rst_stall");
        cyc(1'b0, 1'b0, 1'b1, "stl_F", 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, "stl_D", 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b0, 1'b1, "stl_E_held", 8'h00, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, "stl_E_rel", 8'h00, 16'h1000, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, "stl_W", 8'h01, 16'h1000, 1'b0, 1'b1, 1'b0, 1'b0);
        seq3("stl_next", 8'h01, 16'h1000, 16'h0000, 1'b0);

        // Reset during WB suppresses reg_we and restarts at 0
        do_reset("rst_wb0");
        cyc(1'b0, 1'b0, 1'b1, "rwb_F", 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, "rwb_D", 8'h00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, "rwb_E", 8'h00, 16'h1000, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, "rwb_W_rst", 8'h01, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
        seq_alu("rwb_again", 8'h00, 16'h0000, 16'h1000);

        @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", expq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
